// File: rtl/lighthouse_frame_scheduler_if.sv
// SPI-side handshake between the frame scheduler and the SPI master.
// The scheduler pulses data_ready_o and holds frame_select_o until ss_n releases.
interface lighthouse_frame_scheduler_if;
  logic       data_ready_o;
  logic [3:0] frame_select_o;
  logic       spi_ss_n_i;

  modport master (
    output data_ready_o,
    output frame_select_o,
    input  spi_ss_n_i
  );

  modport slave (
    input  data_ready_o,
    input  frame_select_o,
    output spi_ss_n_i
  );
endinterface

// File: rtl/lighthouse_frame_scheduler.sv
// Round-robin scheduler for lighthouse sensor frames sent over ESP8266 SPI.
// Tracks fresh frames, starts transfers, waits for ss_n release, enforces a gap.
module lighthouse_frame_scheduler #(
  parameter int NUMBER_OF_SENSORS = 8,
  parameter int INTER_FRAME_GAP   = 1024,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUMBER_OF_SENSORS-1:0] sync_i,
  input  logic                         trigger_i,
  input  logic                         enable_i,
  lighthouse_frame_scheduler_if.master spi,
  output logic [15:0]                  pending_o,
  output logic                         busy_o,
  output logic [15:0]                  frames_sent_o,
  output logic [7:0]                   timeout_count_o
);

  localparam int F = (NUMBER_OF_SENSORS + 7) / 8;
  localparam int CMAX = (TIMEOUT_CYCLES > INTER_FRAME_GAP) ?
                        TIMEOUT_CYCLES : INTER_FRAME_GAP;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [15:0] FMASK = 16'((1 << F) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pending_q, pending_d;
  logic [3:0]    rr_q, rr_d;
  logic [3:0]    sel_q, sel_d;
  logic          dr_q, dr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   sent_q, sent_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          ssp_q;

  logic [15:0]   set_vec;
  logic [15:0]   clr_vec;
  logic [15:0]   rset_vec;
  logic          pick_found;
  logic [3:0]    pick_idx;
  logic [CW-1:0] cnt_inc;
  logic          done;

  // exact modulo-F wrap of (value < 2F)
  function automatic logic [3:0] wrap(input int v);
    return (v >= F) ? 4'(v - F) : 4'(v);
  endfunction

  assign done    = !ssp_q && spi.spi_ss_n_i;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    set_vec = '0;
    for (int s = 0; s < NUMBER_OF_SENSORS; s++) begin
      set_vec[s/8] = set_vec[s/8] | sync_i[s];
    end
    if (trigger_i) set_vec = FMASK;
  end

  // reverse scan so the index closest to rr_q wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = F - 1; i >= 0; i--) begin
      if (pending_q[wrap(int'(rr_q) + i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap(int'(rr_q) + i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    clr_vec  = '0;
    rset_vec = '0;
    rr_d     = rr_q;
    sel_d    = sel_q;
    dr_d     = 1'b0;
    cnt_d    = cnt_q;
    sent_d   = sent_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i && |pending_q) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          clr_vec = 16'(1) << pick_idx;
          dr_d    = 1'b1;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          sent_d  = sent_q + 16'd1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
          rset_vec = 16'(1) << sel_q;
          cnt_d    = '0;
          state_d  = S_GAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        if (cnt_inc == CW'(INTER_FRAME_GAP)) begin
          rr_d    = wrap(int'(sel_q) + 1);
          cnt_d   = '0;
          state_d = (enable_i && |pending_q) ? S_ARB : S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = ((pending_q & ~clr_vec) | set_vec | rset_vec) & FMASK;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      sel_q     <= '0;
      dr_q      <= 1'b0;
      cnt_q     <= '0;
      sent_q    <= '0;
      tmo_q     <= '0;
      ssp_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      dr_q      <= dr_d;
      cnt_q     <= cnt_d;
      sent_q    <= sent_d;
      tmo_q     <= tmo_d;
      ssp_q     <= spi.spi_ss_n_i;
    end
  end

  assign spi.data_ready_o   = dr_q;
  assign spi.frame_select_o = sel_q;
  assign pending_o          = pending_q;
  assign busy_o             = (state_q != S_IDLE);
  assign frames_sent_o      = sent_q;
  assign timeout_count_o    = tmo_q;

endmodule

// File: doc/lighthouse_frame_scheduler.md
Name: lighthouse_frame_scheduler

Overview:
Sequences SPI transmission of decoded lighthouse sensor frames. Each frame is 256 bits and holds 8 sensors. The block tracks which frames have fresh sync events and picks one round-robin. It drives the frame-select mux and the dataReady pulse of the ESP8266 SPI control, then waits for slave-select release and enforces an inter-frame gap. Only frames with new data are sent, and a stuck SPI transfer is recovered by a timeout.

Parameters:
NUMBER_OF_SENSORS, 8, number of lighthouse sensors; frames F = ceil(NUMBER_OF_SENSORS/8), legal F range 1..16.
INTER_FRAME_GAP, 1024, idle clock cycles after each frame before the next arbitration (minimum 1).
TIMEOUT_CYCLES, 65535, maximum cycles in WAIT_DONE before the transfer is abandoned.

Ports:
clock  in  1  system clock.
reset_n  in  1  reset; asynchronous, active-low.
sync_i  in  NUMBER_OF_SENSORS  per-sensor non-skipping-sweep flag; level, sampled every cycle.
trigger_i  in  1  debug force-send; marks all frames pending.
enable_i  in  1  allows new arbitrations; does not abort a transfer in flight.
spi_ss_n_i  in  1  slave select from the SPI master; a rising edge means the frame is done.
data_ready_o  out  1  one-cycle pulse that starts a frame transfer.
frame_select_o  out  4  index of the frame to present on the SPI data bus.
pending_o  out  16  pending bitmap; bits >= F are always 0.
busy_o  out  1  high in every state except IDLE.
frames_sent_o  out  16  completed-frame counter; wraps at 2^16.
timeout_count_o  out  8  abandoned-transfer counter; saturates at 255.

Behaviour:
- Reset values: all outputs 0, pending 0, rr_ptr 0, state IDLE, ss_n_prev 1.
- Pending set: bit f is set on any cycle where OR(sync_i[8f+7:8f]) = 1; the last frame uses only the sensors that exist. trigger_i sets bits 0..F-1.
- Pending clear: only in ARBITRATE, for the chosen frame. If set and clear hit the same bit in the same cycle, set wins.
- ss_n_prev is registered every cycle. done = !ss_n_prev && spi_ss_n_i. done is ignored outside WAIT_DONE.
- IDLE: if enable_i && |pending, go to ARBITRATE; otherwise stay.
- ARBITRATE (1 cycle):
  - Choose the first pending index scanning rr_ptr, rr_ptr+1, ... modulo F.
  - Register frame_select_o and clear that pending bit.
  - Go to SEND.
  - If pending became 0 (cannot happen, but must be handled), return to IDLE.
- SEND (1 cycle): data_ready_o = 1 (registered, high for exactly this cycle). Clear the timeout counter. Go to WAIT_DONE.
- WAIT_DONE:
  - On done: frames_sent_o += 1, go to GAP.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES, timeout_count_o += 1 (saturating), the chosen frame's pending bit is set again, and the FSM goes to GAP.
- GAP:
  - Count INTER_FRAME_GAP cycles, then rr_ptr <= (frame_select_o + 1) mod F.
  - Then go to ARBITRATE if enable_i && |pending, else IDLE.
- frame_select_o holds its value from ARBITRATE until the next ARBITRATE. The SPI data must stay stable for the whole transfer.
- Latency: from IDLE with enable_i = 1, sync_i high at clock edge t gives pending set at t and ARBITRATE at t+1. data_ready_o is high in the cycle after edge t+2.
- enable_i falling mid-transfer: the current frame completes normally (GAP included), then the FSM parks in IDLE. Pending keeps accumulating.
- F = 1: rr_ptr and frame_select_o stay 0.
- reset_n asserted mid-transfer: everything returns to reset values immediately. data_ready_o drops asynchronously.
- Width rules: counters are unsigned; the modulo F wrap is exact for non-power-of-two F.

Test Plan:
- NUMBER_OF_SENSORS=20 (F=3), INTER_FRAME_GAP=4. Pulse sync_i[17] for 1 cycle. Required: data_ready_o for 1 cycle with frame_select_o=2; pending_o=0 afterwards; after ss_n 0->1, frames_sent_o=1.
- Round-robin: hold sync_i[0], sync_i[9] and sync_i[18] high continuously, ack each frame. Required: frame_select_o sequence 0,1,2,0,1,2 with no starvation; gap between ss_n rising edge and next data_ready_o of at least 4 cycles.
- Timeout: TIMEOUT_CYCLES=100, single sync in frame 1, never toggle ss_n. Required: timeout_count_o=1 after about 100 cycles; frame 1 re-sent with data_ready_o pulse again; frames_sent_o=0.
- Set/clear collision: assert sync_i[8] in the exact ARBITRATE cycle that picks frame 1. Required: pending_o[1] stays 1 and frame 1 is sent a second time.
- enable_i low during WAIT_DONE, with trigger_i pulsed meanwhile. Required: current frame completes, busy_o falls after GAP, pending_o=3'b111, no data_ready_o until enable_i returns high.
- Reset asserted mid-WAIT_DONE. Required: all outputs 0 immediately; no data_ready_o after release until a new sync.
